comp_share_arbiter: RTL and testbench
=====================================

// Module: comp_share_arbiter
// PURPOSE
//   Shares one unsigned magnitude comparator (COMP) among NREQ requesters.
//   Round-robin arbitration, operand capture, registered gt/lt/eq result,
//   valid/ready response channel tagged with requester id. Sits between
//   scheduled datapath ops and the single comparator resource.
// PARAMETERS
//   DATAWIDTH  8   operand width, unsigned
//   NREQ       4   number of requesters, >=2, need not be a power of 2
//   IDW        $clog2(NREQ)  localparam, id width
// PORTS
//   Clk        in   1               clock, rising edge
//   Rst        in   1               reset, asynchronous, active-low
//   req_valid  in   NREQ            per-requester request
//   req_a      in   NREQ*DATAWIDTH  operand a; requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_b      in   NREQ*DATAWIDTH  operand b; same packing
//   req_ready  out  NREQ            one-hot accept strobe, combinational
//   rsp_valid  out  1               result valid
//   rsp_ready  in   1               consumer accepts result
//   rsp_id     out  IDW             requester that owns the result
//   rsp_gt     out  1               a > b
//   rsp_lt     out  1               a < b
//   rsp_eq     out  1               a == b
//   busy       out  1               high whenever state != IDLE
// BEHAVIOUR
//   Reset (Rst=0, async): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0,
//     rsp_gt/lt/eq=0, captured operands=0. In-flight request discarded.
//   FSM, one request in flight:
//   IDLE: if |req_valid: grant = first set bit scanning rr_ptr, rr_ptr+1, ...,
//     wrapping NREQ-1 -> 0. req_ready[grant]=1 this cycle (only when IDLE);
//     capture req_a/req_b slice and grant id; -> CMP. Else stay.
//   CMP: captured operands drive COMP; gt/lt/eq and id registered into rsp_*;
//     rsp_valid<=1; -> RESP. rsp_ready ignored.
//   RESP: rsp_* held stable. On rsp_ready: rsp_valid<=0,
//     rr_ptr <= (rsp_id==NREQ-1) ? 0 : rsp_id+1; -> IDLE.
//   Latency: accept edge T -> rsp_valid high after edge T+2. With rsp_ready tied
//     high, one result per 3 cycles; next grant earliest cycle after handshake.
//   req_ready all-zero outside IDLE. Transfer = req_valid[i] & req_ready[i].
//   Requester may drop req_valid before grant; no state effect.
//   Exactly one of rsp_gt/lt/eq high while rsp_valid=1; all 0 after reset.
//   Compare is unsigned, full DATAWIDTH; no extension or truncation.
//   Simultaneous valids: round-robin only; never starves (NREQ-grant bound).
//   req_valid changing in CMP/RESP: ignored, operands already captured.
//   Reset asserted in CMP/RESP: result lost, no rsp_valid pulse.
// STRUCTURE
//   Shared header comp_defs.vh: state encodings ST_IDLE=2'd0, ST_CMP=2'd1,
//     ST_RESP=2'd2 (2'd3 illegal -> IDLE).
//   Sub-module rr_grant: combinational rotate-priority pick
//     (req_valid, rr_ptr) -> grant one-hot + grant_id + any.
//   Existing COMP instantiated once with DATAWIDTH passed through.
// TESTING (DATAWIDTH=8, NREQ=4)
//   1 Reset: Rst=0 mid-RESP -> rsp_valid=0, busy=0, rsp_id=0 immediately;
//     first grant after release goes to requester 0.
//   2 Single: req_valid=4'b0100, a2=8'hC8, b2=8'h37, rsp_ready=1 -> req_ready=4'b0100
//     at T, rsp_valid at T+2 with id=2, gt=1 lt=0 eq=0.
//   3 Equal/lt: a=8'hFF,b=8'hFF -> eq=1; a=8'h00,b=8'h01 -> lt=1.
//   4 Fairness: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0;
//     one grant every 3 cycles.
//   5 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0,
//     busy=1; rsp_ready=1 -> handshake, IDLE next cycle.
//   6 Wrap: NREQ=3, last grant id=2, req_valid=3'b101 -> next grant id=0.

Source files
------------

// File: rtl/comp_share_arbiter_pkg.sv
// Shared definitions for the comparator-sharing arbiter.
//   ST_*       : FSM state encodings (2'd3 is illegal and recovers to IDLE)
//   cmp_res_t  : registered comparator result {gt, lt, eq}
package comp_share_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

endpackage

// File: rtl/comp_share_arbiter_comp.sv
// Unsigned magnitude comparator, the single shared resource.
//   a_i, b_i      : unsigned operands, full DATAWIDTH
//   gt_o/lt_o/eq_o: exactly one is high
module comp_share_arbiter_comp #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic                 gt_o,
  output logic                 lt_o,
  output logic                 eq_o
);

  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comp_share_arbiter_rr_grant.sv
// Rotate-priority picker: scans req_valid_i starting at rr_ptr_i, wrapping
// NREQ-1 -> 0, and returns the first set requester.
//   req_valid_i : per-requester request
//   rr_ptr_i    : highest-priority requester this cycle (< NREQ)
//   grant_o     : one-hot grant (all zero when nothing requested)
//   grant_id_o  : index of the granted requester
//   any_o       : at least one request present
module comp_share_arbiter_rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            any_o
);

  int idx;

  assign any_o = |req_valid_i;

  // Walk offsets from farthest to nearest so the nearest set bit to rr_ptr
  // is the last write and wins. NREQ need not be a power of two, so the
  // wrap is an explicit subtract rather than natural overflow.
  always_comb begin
    grant_id_o = '0;
    idx        = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid_i[idx]) grant_id_o = IDW'(idx);
    end
  end

  assign grant_o = any_o ? (NREQ'(1) << grant_id_o) : '0;

endmodule

// File: rtl/comp_share_arbiter.sv
// Shares one unsigned comparator among NREQ requesters with round-robin
// arbitration and a single request in flight (IDLE -> CMP -> RESP).
//   Clk        : clock, rising edge
//   Rst        : asynchronous active-low reset
//   req_valid  : per-requester request
//   req_a/b    : operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_ready  : one-hot accept strobe, combinational, only in IDLE
//   rsp_valid/rsp_ready : result handshake
//   rsp_id     : requester owning the result
//   rsp_gt/lt/eq : registered compare result, held while rsp_valid
//   busy       : high whenever not IDLE
module comp_share_arbiter
  import comp_share_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic                      rsp_gt,
  output logic                      rsp_lt,
  output logic                      rsp_eq,
  output logic                      busy
);

  logic [1:0]           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  cmp_res_t             res_q, res_d, cmp_res;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            any_req;

  comp_share_arbiter_rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .any_o       (any_req)
  );

  comp_share_arbiter_comp #(.DATAWIDTH(DATAWIDTH)) u_comp (
    .a_i  (a_q),
    .b_i  (b_q),
    .gt_o (cmp_res.gt),
    .lt_o (cmp_res.lt),
    .eq_o (cmp_res.eq)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    res_d       = res_q;
    case (state_q)
      ST_IDLE: if (any_req) begin
        a_d     = req_a[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
        b_d     = req_b[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
        id_d    = grant_id;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        res_d       = cmp_res;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        // Priority moves to the requester just after the one served.
        rr_ptr_d    = (rsp_id_q == IDW'(NREQ-1)) ? '0 : rsp_id_q + 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      res_q       <= res_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = res_q.gt;
  assign rsp_lt    = res_q.lt;
  assign rsp_eq    = res_q.eq;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Bench for comp_share_arbiter: directed vector table, hand sequences for
// reset/fairness/backpressure/wrap, and a randomized run against a
// transaction-level reference model.
module tb_comp_share_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*DW-1:0]   req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_gt, rsp_lt, rsp_eq, busy;
  logic [1:0]        rsp_id;

  // Three-requester instance for the non-power-of-two wrap case.
  logic [2:0]        rv3, rr3;
  logic [3*DW-1:0]   a3, b3;
  logic              rspv3, rspr3, gt3, lt3, eq3, busy3;
  logic [1:0]        id3;

  comp_share_arbiter #(.DATAWIDTH(DW), .NREQ(N)) dut (
    .Clk(clk), .Rst(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .busy(busy)
  );

  comp_share_arbiter #(.DATAWIDTH(DW), .NREQ(3)) dut3 (
    .Clk(clk), .Rst(rst_n), .req_valid(rv3), .req_a(a3), .req_b(b3),
    .req_ready(rr3), .rsp_valid(rspv3), .rsp_ready(rspr3),
    .rsp_id(id3), .rsp_gt(gt3), .rsp_lt(lt3), .rsp_eq(eq3), .busy(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] gle;   // {gt, lt, eq}
  } vec_t;

  vec_t tbl[6];

  // Reference model state for the random run
  bit         m_out;
  int         m_age, m_ptr, m_id, m_pick;
  bit         m_found;
  logic [7:0] m_a, m_b;
  logic [3:0] m_rdy;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2, 8'hC8, 8'h37, 3'b100};
    tbl[1] = '{1, 8'hFF, 8'hFF, 3'b001};
    tbl[2] = '{3, 8'h00, 8'h01, 3'b010};
    tbl[3] = '{0, 8'h80, 8'h7F, 3'b100};
    tbl[4] = '{2, 8'h7F, 8'h80, 3'b010};
    tbl[5] = '{3, 8'h00, 8'h00, 3'b001};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rv3 = '0; a3 = '0; b3 = '0; rspr3 = 1'b1;
    #12;
    chk("reset_outputs", {rsp_valid, busy, rsp_id, rsp_gt, rsp_lt, rsp_eq}, '0);
    chk("reset_ready", 32'(req_ready), 0);
    cyc();
    rst_n = 1'b1;

    // Directed vectors, one requester at a time
    foreach (tbl[i]) begin
      cyc();
      req_valid = 4'b1 << tbl[i].id;
      req_a = $urandom; req_b = $urandom;
      req_a[tbl[i].id*DW +: DW] = tbl[i].a;
      req_b[tbl[i].id*DW +: DW] = tbl[i].b;
      rsp_ready = 1'b1;
      #1;
      chk("vec_ready", 32'(req_ready), 32'(4'b1 << tbl[i].id));
      chk("vec_idle_busy", 32'(busy), 0);
      cyc();
      req_valid = '0;
      #1;
      chk("vec_cmp_phase", {rsp_valid, busy, req_ready}, {1'b0, 1'b1, 4'b0});
      cyc();
      #1;
      chk("vec_rsp_valid", 32'(rsp_valid), 1);
      chk("vec_rsp_id", 32'(rsp_id), 32'(tbl[i].id));
      chk("vec_rsp_gle", {rsp_gt, rsp_lt, rsp_eq}, tbl[i].gle);
    end

    // Reset while holding a result in RESP
    cyc();
    req_valid = 4'b0100; req_a = 32'h00C8_0000; req_b = 32'h0037_0000; rsp_ready = 1'b0;
    cyc();
    req_valid = '0;
    cyc();
    #1;
    chk("rst_pre_valid", 32'(rsp_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {rsp_valid, busy, rsp_id, rsp_gt, rsp_lt, rsp_eq}, '0);
    cyc();
    rsp_ready = 1'b1;
    rst_n = 1'b1;

    // Fairness: all requesting, order 0,1,2,3,0, one grant per 3 cycles
    req_valid = 4'b1111; req_a = $urandom; req_b = $urandom;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("fair_grant", 32'(req_ready), 32'(4'b1 << (g % 4)));
      cyc();
      #1;
      chk("fair_cmp_ready", 32'(req_ready), 0);
      cyc();
      #1;
      chk("fair_rsp", {rsp_valid, rsp_id}, {1'b1, 2'(g % 4)});
      cyc();
    end
    req_valid = '0;

    // Backpressure: hold result 5 cycles while inputs churn
    cyc();
    req_valid = 4'b0010; req_a = 32'h0000_1000; req_b = 32'h0000_2000; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'(4'b0010));
    cyc();
    req_valid = '0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'($urandom); req_a = $urandom; req_b = $urandom;
      #1;
      chk("bp_hold", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {1'b1, 2'd1, 3'b010});
      chk("bp_ready_busy", {req_ready, busy}, {4'b0, 1'b1});
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b1;
    #1;
    chk("bp_before_hs", 32'(rsp_valid), 1);
    cyc();
    #1;
    chk("bp_after_hs", {rsp_valid, busy}, 2'b00);

    // Wrap on a three-requester instance: after id 2, requester 0 wins over 2
    cyc();
    rv3 = 3'b100; a3 = 24'h05_0000; b3 = 24'h09_0000;
    #1;
    chk("wrap_first", 32'(rr3), 32'(3'b100));
    cyc();
    rv3 = '0;
    cyc();
    #1;
    chk("wrap_first_id", {rspv3, id3, gt3, lt3, eq3}, {1'b1, 2'd2, 3'b010});
    cyc();
    rv3 = 3'b101; a3 = 24'h05_0009; b3 = 24'h09_0009;
    #1;
    chk("wrap_next", 32'(rr3), 32'(3'b001));
    cyc();
    rv3 = '0;
    cyc();
    #1;
    chk("wrap_next_id", {rspv3, id3, gt3, lt3, eq3}, {1'b1, 2'd0, 3'b001});
    cyc();

    // Randomized run against the transaction-level model
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    m_out = 0; m_age = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      cyc();
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      req_a = $urandom;
      req_b = ($urandom_range(0, 3) == 0) ? req_a : $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!m_out) begin
        m_found = 0; m_pick = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && req_valid[(m_ptr + k) % N]) begin
            m_found = 1; m_pick = (m_ptr + k) % N;
          end
        end
        m_rdy = m_found ? (4'b1 << m_pick) : 4'b0;
        chk("rnd_ready", 32'(req_ready), 32'(m_rdy));
        chk("rnd_idle", {rsp_valid, busy}, 2'b00);
        if (m_found) begin
          m_out = 1; m_age = 1; m_id = m_pick;
          m_a = req_a[m_pick*DW +: DW];
          m_b = req_b[m_pick*DW +: DW];
        end
      end else begin
        chk("rnd_busy", {req_ready, busy}, {4'b0, 1'b1});
        if (m_age < 2) begin
          chk("rnd_cmp_valid", 32'(rsp_valid), 0);
        end else begin
          chk("rnd_rsp", {rsp_valid, rsp_id}, {1'b1, 2'(m_id)});
          chk("rnd_gle", {rsp_gt, rsp_lt, rsp_eq}, {m_a > m_b, m_a < m_b, m_a == m_b});
          if (rsp_ready) begin
            m_out = 0;
            m_ptr = (m_id + 1) % N;
          end
        end
        m_age++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
